// File: rtl/noc_credit_link_bundle_if.sv
// Per-link flit and credit signals between upstream router, link bundle and downstream router.
// master = the side driving the *_in signals, slave = the link bundle itself.
interface noc_credit_link_bundle_if #(
    parameter int NUM_LINKS  = 4,
    parameter int FLIT_WIDTH = 128,
    parameter int DEST_WIDTH = 6
);
    logic [0:NUM_LINKS-1][FLIT_WIDTH-1:0] data_in;
    logic [0:NUM_LINKS-1][DEST_WIDTH-1:0] dest_in;
    logic [0:NUM_LINKS-1]                 is_tail_in;
    logic [0:NUM_LINKS-1]                 send_in;
    logic [0:NUM_LINKS-1]                 credit_out;
    logic [0:NUM_LINKS-1][FLIT_WIDTH-1:0] data_out;
    logic [0:NUM_LINKS-1][DEST_WIDTH-1:0] dest_out;
    logic [0:NUM_LINKS-1]                 is_tail_out;
    logic [0:NUM_LINKS-1]                 send_out;
    logic [0:NUM_LINKS-1]                 credit_in;

    modport master (
        output data_in, dest_in, is_tail_in, send_in, credit_in,
        input  credit_out, data_out, dest_out, is_tail_out, send_out
    );

    modport slave (
        input  data_in, dest_in, is_tail_in, send_in, credit_in,
        output credit_out, data_out, dest_out, is_tail_out, send_out
    );
endinterface

// File: rtl/noc_credit_link_bundle.sv
// Pipelined router-to-router flit/credit link bundle with optional credit monitor.
// Define NOC_LINK_MONITOR_EN to build the per-link credit counter and error flags.
module noc_credit_link_bundle #(
    parameter int NUM_LINKS         = 4,
    parameter int FLIT_WIDTH        = 128,
    parameter int DEST_WIDTH        = 6,
    parameter int NUM_PIPELINE      = 2,
    parameter int FLIT_BUFFER_DEPTH = 8,
    localparam int CREDIT_WIDTH     = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                                   clk_noc,
    input  logic                                   rst_noc_sync,
    noc_credit_link_bundle_if.slave                lnk,
    output logic [0:NUM_LINKS-1][CREDIT_WIDTH-1:0] credit_avail,
    output logic [0:NUM_LINKS-1]                   err_overflow,
    output logic [0:NUM_LINKS-1]                   err_underflow,
    output logic                                   err_any
);

    if (NUM_PIPELINE == 0) begin : g_comb
        assign lnk.data_out    = lnk.data_in;
        assign lnk.dest_out    = lnk.dest_in;
        assign lnk.is_tail_out = lnk.is_tail_in;
        assign lnk.send_out    = lnk.send_in;
        assign lnk.credit_out  = lnk.credit_in;
    end else begin : g_pipe
        logic [0:NUM_LINKS-1][FLIT_WIDTH-1:0] data_q [NUM_PIPELINE];
        logic [0:NUM_LINKS-1][DEST_WIDTH-1:0] dest_q [NUM_PIPELINE];
        logic [0:NUM_LINKS-1]                 tail_q [NUM_PIPELINE];
        logic [0:NUM_LINKS-1]                 send_q [NUM_PIPELINE];
        logic [0:NUM_LINKS-1]                 cred_q [NUM_PIPELINE];

        // Stages load every cycle so bubbles travel with send=0.
        always_ff @(posedge clk_noc) begin
            if (rst_noc_sync) begin
                for (int s = 0; s < NUM_PIPELINE; s++) begin
                    data_q[s] <= '0;
                    dest_q[s] <= '0;
                    tail_q[s] <= '0;
                    send_q[s] <= '0;
                    cred_q[s] <= '0;
                end
            end else begin
                data_q[0] <= lnk.data_in;
                dest_q[0] <= lnk.dest_in;
                tail_q[0] <= lnk.is_tail_in;
                send_q[0] <= lnk.send_in;
                cred_q[0] <= lnk.credit_in;
                for (int s = 1; s < NUM_PIPELINE; s++) begin
                    data_q[s] <= data_q[s-1];
                    dest_q[s] <= dest_q[s-1];
                    tail_q[s] <= tail_q[s-1];
                    send_q[s] <= send_q[s-1];
                    cred_q[s] <= cred_q[s-1];
                end
            end
        end

        assign lnk.data_out    = data_q[NUM_PIPELINE-1];
        assign lnk.dest_out    = dest_q[NUM_PIPELINE-1];
        assign lnk.is_tail_out = tail_q[NUM_PIPELINE-1];
        assign lnk.send_out    = send_q[NUM_PIPELINE-1];
        assign lnk.credit_out  = cred_q[NUM_PIPELINE-1];
    end

`ifdef NOC_LINK_MONITOR_EN
    localparam logic [CREDIT_WIDTH-1:0] DEPTH = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
    localparam logic [CREDIT_WIDTH-1:0] ONE   = CREDIT_WIDTH'(1);

    logic [0:NUM_LINKS-1][CREDIT_WIDTH-1:0] cnt_q;
    logic [0:NUM_LINKS-1]                   ovf_q;
    logic [0:NUM_LINKS-1]                   udf_q;

    // Counts credits held upstream: a send spends one, a returned credit refunds one.
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            for (int l = 0; l < NUM_LINKS; l++) cnt_q[l] <= DEPTH;
            ovf_q <= '0;
            udf_q <= '0;
        end else begin
            for (int l = 0; l < NUM_LINKS; l++) begin
                unique case ({lnk.send_in[l], lnk.credit_out[l]})
                    2'b10: begin
                        if (cnt_q[l] == '0) ovf_q[l] <= 1'b1;
                        else cnt_q[l] <= cnt_q[l] - ONE;
                    end
                    2'b01: begin
                        if (cnt_q[l] == DEPTH) udf_q[l] <= 1'b1;
                        else cnt_q[l] <= cnt_q[l] + ONE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign credit_avail  = cnt_q;
    assign err_overflow  = ovf_q;
    assign err_underflow = udf_q;
    assign err_any       = |{ovf_q, udf_q};
`else
    assign credit_avail  = '0;
    assign err_overflow  = '0;
    assign err_underflow = '0;
    assign err_any       = 1'b0;
`endif

endmodule
